vga_palette_arbiter: RTL and testbench



---
 rtl/vga_palette_arbiter.sv | 126 ++++++++++++
 tb/tb_vga_palette_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_palette_arbiter.sv
// rtl/vga_palette_arbiter.sv - palette RAM arbiter: scan-out priority, buffered CPU writes, ordered CPU reads
module vga_palette_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_active,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  input  logic              vblank,
  input  logic              sync_mode,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_wr_ack,
  input  logic              cpu_rd_req,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_rd_valid,
  output logic [2:0]        fifo_level,
  output logic              fifo_full,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DONE} rd_state_t;

  rd_state_t         rd_state;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [2:0]        level_next;
  logic              push;
  logic              pop;
  logic              rd_grant;
  logic              scan_pend;

  // A read waits for an empty FIFO so it always observes the newest buffered write.
  always_comb begin
    push     = rst_n & cpu_wr_req & ~fifo_full;
    rd_grant = rst_n & ~scan_active & (rd_state == R_IDLE) & cpu_rd_req & (fifo_level == 3'd0);
    pop      = rst_n & ~scan_active & ~rd_grant & (fifo_level != 3'd0) & (~sync_mode | vblank);
  end

  assign cpu_wr_ack = push;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (rst_n) begin
      if (scan_active) begin
        ram_en   = 1'b1;
        ram_addr = scan_addr;
      end else if (rd_grant) begin
        ram_en   = 1'b1;
        ram_addr = cpu_rd_addr;
      end else if (pop) begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = fifo_addr[rd_ptr];
        ram_wdata = fifo_data[rd_ptr];
      end
    end
  end

  always_comb begin
    case ({push, pop})
      2'b10:   level_next = fifo_level + 3'd1;
      2'b01:   level_next = fifo_level - 3'd1;
      default: level_next = fifo_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_wr_addr;
      fifo_data[wr_ptr] <= cpu_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= 3'd0;
      fifo_full    <= 1'b0;
      scan_pend    <= 1'b0;
      scan_data    <= '0;
      rd_state     <= R_IDLE;
      cpu_rd_data  <= '0;
      cpu_rd_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= level_next;
      fifo_full  <= (level_next == 3'(FIFO_DEPTH));

      // RAM returns data one cycle after the scan address; capture only real scan reads.
      scan_pend <= scan_active;
      if (scan_pend) scan_data <= ram_rdata;

      cpu_rd_valid <= 1'b0;
      case (rd_state)
        R_IDLE: if (rd_grant) rd_state <= R_WAIT;
        R_WAIT: begin
          cpu_rd_data  <= ram_rdata;
          cpu_rd_valid <= 1'b1;
          rd_state     <= R_DONE;
        end
        R_DONE:  rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_palette_arbiter.sv
// tb/tb_vga_palette_arbiter.sv - directed self-checking bench for vga_palette_arbiter
module tb_vga_palette_arbiter;

  logic       clk;
  logic       rst_n;
  logic       scan_active;
  logic [5:0] scan_addr;
  logic [7:0] scan_data;
  logic       vblank;
  logic       sync_mode;
  logic       cpu_wr_req;
  logic [5:0] cpu_wr_addr;
  logic [7:0] cpu_wr_data;
  logic       cpu_wr_ack;
  logic       cpu_rd_req;
  logic [5:0] cpu_rd_addr;
  logic [7:0] cpu_rd_data;
  logic       cpu_rd_valid;
  logic [2:0] fifo_level;
  logic       fifo_full;
  logic       ram_en;
  logic       ram_we;
  logic [5:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  vga_palette_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .scan_active(scan_active), .scan_addr(scan_addr), .scan_data(scan_data),
    .vblank(vblank), .sync_mode(sync_mode),
    .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_wr_ack(cpu_wr_ack),
    .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_data(cpu_rd_data),
    .cpu_rd_valid(cpu_rd_valid),
    .fifo_level(fifo_level), .fifo_full(fifo_full),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pal_init(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  // Behavioural single-port palette RAM, preloaded on its first clock.
  logic [7:0] ram [64];
  logic       ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 64; i++) ram[i] <= pal_init(i);
      ram_loaded <= 1'b1;
    end else begin
      if (ram_en && ram_we)  ram[ram_addr] <= ram_wdata;
      if (ram_en && !ram_we) ram_rdata <= ram[ram_addr];
    end
  end

  logic [7:0] exp_pal [64];
  logic [7:0] scanq [$];
  logic [7:0] rdq [$];
  logic [7:0] last_scan;
  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [5:0] a, input int exp_grant);
    int grant;
    bit got;
    grant = -1;
    got   = 1'b0;
    rdq.push_back(exp_pal[a]);
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = a;
    for (int c = 0; c < 12 && !got; c++) begin
      #1;
      if (grant < 0 && ram_en && !ram_we) grant = c;
      tick();
      if (cpu_rd_valid) begin
        got = 1'b1;
        check("rd_grant_cycle", grant, exp_grant);
        check("rd_latency", c + 1 - grant, 2);
        check("rd_data", cpu_rd_data, rdq.pop_front());
        cpu_rd_req = 1'b0;
      end
    end
    check("rd_valid_seen", got, 1);
    if (!got) begin
      cpu_rd_req = 1'b0;
      void'(rdq.pop_front());
    end
    tick();
    check("rd_valid_pulse", cpu_rd_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) exp_pal[i] = pal_init(i);
    rst_n       = 1'b0;
    scan_active = 1'b1;
    scan_addr   = 6'd5;
    vblank      = 1'b0;
    sync_mode   = 1'b0;
    cpu_wr_req  = 1'b1;
    cpu_wr_addr = 6'd0;
    cpu_wr_data = pal_init(0);
    cpu_rd_req  = 1'b0;
    cpu_rd_addr = 6'd0;
    @(negedge clk);

    // Reset held three cycles with a write pending.
    for (int r = 0; r < 3; r++) begin
      #1;
      check("rst_ack", cpu_wr_ack, 0);
      check("rst_ram_en", ram_en, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_wdata", ram_wdata, 0);
      tick();
      check("rst_level", fifo_level, 0);
      check("rst_full", fifo_full, 0);
      check("rst_scan_data", scan_data, 0);
      check("rst_rd_data", cpu_rd_data, 0);
      check("rst_rd_valid", cpu_rd_valid, 0);
    end
    scan_active = 1'b0;
    rst_n       = 1'b1;
    #1 check("first_ack", cpu_wr_ack, 1);
    tick();
    cpu_wr_req = 1'b0;
    check("first_level", fifo_level, 1);
    #1;
    check("first_drain_we", ram_we, 1);
    check("first_drain_addr", ram_addr, 0);
    tick();
    check("first_level_empty", fifo_level, 0);

    // Scan sweep 0..63 with two writes buffered behind it.
    for (int i = 0; i < 64; i++) begin
      if (scanq.size() == 2) check("scan_data", scan_data, scanq.pop_front());
      scan_active = 1'b1;
      scan_addr   = 6'(i);
      scanq.push_back(pal_init(i));
      cpu_wr_req  = (i < 2);
      cpu_wr_addr = 6'(40 + i);
      cpu_wr_data = (i == 0) ? 8'h5A : 8'hA5;
      #1;
      check("scan_no_write", ram_we, 0);
      if (i < 2) begin
        check("scan_wr_ack", cpu_wr_ack, 1);
        exp_pal[40 + i] = cpu_wr_data;
      end
      tick();
    end
    scan_active = 1'b0;
    cpu_wr_req  = 1'b0;
    for (int j = 0; j < 2; j++) begin
      last_scan = scanq.pop_front();
      check("scan_data_tail", scan_data, last_scan);
      #1;
      check("post_scan_drain_we", ram_we, 1);
      check("post_scan_drain_addr", ram_addr, 40 + j);
      check("post_scan_drain_data", ram_wdata, exp_pal[40 + j]);
      tick();
    end
    check("scan_data_hold", scan_data, last_scan);
    tick();
    check("scan_data_hold2", scan_data, last_scan);
    check("post_scan_level", fifo_level, 0);

    // FIFO full: five back-to-back writes while scan owns the RAM.
    scan_active = 1'b1;
    scan_addr   = 6'd0;
    for (int k = 0; k < 5; k++) begin
      cpu_wr_req  = 1'b1;
      cpu_wr_addr = 6'(k + 1);
      cpu_wr_data = 8'(8'hA1 + k);
      #1;
      check("full_ack", cpu_wr_ack, (k < 4));
      if (k < 4) begin
        exp_pal[k + 1] = cpu_wr_data;
        tick();
      end
    end
    check("full_flag", fifo_full, 1);
    check("full_level", fifo_level, 4);
    scan_active = 1'b0;
    #1;
    check("full_pop_no_ack", cpu_wr_ack, 0);
    check("full_pop_we", ram_we, 1);
    check("full_pop_addr", ram_addr, 1);
    tick();
    #1;
    check("fifth_ack", cpu_wr_ack, 1);
    exp_pal[5] = cpu_wr_data;
    check("second_pop_addr", ram_addr, 2);
    tick();
    cpu_wr_req = 1'b0;
    check("push_pop_level", fifo_level, 3);
    for (int m = 3; m <= 5; m++) begin
      #1;
      check("full_drain_we", ram_we, 1);
      check("full_drain_addr", ram_addr, m);
      check("full_drain_data", ram_wdata, exp_pal[m]);
      tick();
    end
    check("full_drained_level", fifo_level, 0);
    check("full_drained_flag", fifo_full, 0);

    // Sync mode: drain only once vblank rises.
    sync_mode   = 1'b1;
    vblank      = 1'b0;
    cpu_wr_req  = 1'b1;
    cpu_wr_addr = 6'd7;
    cpu_wr_data = 8'h3C;
    #1 check("sync_ack", cpu_wr_ack, 1);
    exp_pal[7] = 8'h3C;
    tick();
    cpu_wr_req = 1'b0;
    check("sync_level", fifo_level, 1);
    for (int s = 0; s < 2; s++) begin
      #1 check("sync_hold_en", ram_en, 0);
      tick();
    end
    vblank = 1'b1;
    #1;
    check("sync_we", ram_we, 1);
    check("sync_addr", ram_addr, 7);
    check("sync_data", ram_wdata, 8'h3C);
    tick();
    check("sync_level_empty", fifo_level, 0);
    sync_mode = 1'b0;
    vblank    = 1'b0;

    // Read after write: grant must wait one cycle for the drain.
    cpu_wr_req  = 1'b1;
    cpu_wr_addr = 6'd9;
    cpu_wr_data = 8'hE0;
    #1 check("raw_ack", cpu_wr_ack, 1);
    exp_pal[9] = 8'hE0;
    tick();
    cpu_wr_req = 1'b0;
    cpu_read(6'd9, 1);
    cpu_read(6'd40, 0);
    cpu_read(6'd5, 0);

    // Reset in R_WAIT drops the read.
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = 6'd7;
    #1 check("midrd_grant", {ram_en, ram_we}, 2'b10);
    tick();
    rst_n      = 1'b0;
    cpu_rd_req = 1'b0;
    tick();
    check("midrd_valid_rst", cpu_rd_valid, 0);
    rst_n = 1'b1;
    for (int q = 0; q < 3; q++) begin
      tick();
      check("midrd_no_valid", cpu_rd_valid, 0);
    end
    cpu_read(6'd7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
